// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: one shift-add or restoring-subtract step per cycle.
// Optional feature macro: MULDIV_UNSIGNED_EN enables the unsigned op path through op[1].
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ZERO, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_bmag;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;

  logic             w_uns;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH:0]   w_aext;
  logic [WIDTH:0]   w_bext;
  logic [WIDTH:0]   w_amag;
  logic [WIDTH:0]   w_bmag;
  logic             w_accept;
  logic             w_dz;
  logic             w_unused;

`ifdef MULDIV_UNSIGNED_EN
  assign w_uns = op[1];
`else
  assign w_uns = 1'b0;
`endif

  // Magnitudes are formed one bit wider so the most-negative operand negates cleanly.
  assign w_sa     = ~w_uns & a[WIDTH-1];
  assign w_sb     = ~w_uns & b[WIDTH-1];
  assign w_aext   = {w_sa, a};
  assign w_bext   = {w_sb, b};
  assign w_amag   = w_sa ? (~w_aext + 1'b1) : w_aext;
  assign w_bmag   = w_sb ? (~w_bext + 1'b1) : w_bext;
  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_dz     = op[0] && (b == '0);

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH+1:0]   w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nx;
  logic [WIDTH-1:0]   w_quo_nx;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_q_s;
  logic [WIDTH-1:0]   w_r_s;
  logic [WIDTH-1:0]   w_hi_res;
  logic [WIDTH-1:0]   w_lo_res;

  // Mult keeps the multiplier in r_quo and shifts product bits into it from the top.
  assign w_sum    = {1'b0, r_rem} + {1'b0, (r_quo[0] ? r_bmag : '0)};
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = {1'b0, w_shift} - {2'b00, r_bmag};
  assign w_ge     = ~w_diff[WIDTH+1];
  assign w_rem_nx = r_div ? (w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]) : w_sum[WIDTH:1];
  assign w_quo_nx = r_div ? {r_quo[WIDTH-2:0], w_ge} : {w_sum[0], r_quo[WIDTH-1:1]};

  assign w_prod   = {w_rem_nx, w_quo_nx};
  assign w_prod_s = r_neg_q ? (~w_prod + 1'b1) : w_prod;
  assign w_q_s    = r_neg_q ? (~w_quo_nx + 1'b1) : w_quo_nx;
  assign w_r_s    = r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;
  assign w_hi_res = r_div ? w_r_s : w_prod_s[2*WIDTH-1:WIDTH];
  assign w_lo_res = r_div ? w_q_s : w_prod_s[WIDTH-1:0];

  assign w_unused = &{w_diff[WIDTH], w_amag[WIDTH], w_bmag[WIDTH], op[1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_div    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bmag   <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (w_accept) begin
            busy     <= 1'b1;
            div_zero <= w_dz;
            if (w_dz) begin
              r_state <= S_ZERO;
            end else begin
              r_state <= S_RUN;
              r_cnt   <= CW'(WIDTH);
              r_div   <= op[0];
              r_neg_q <= w_sa ^ w_sb;
              r_neg_r <= w_sa;
              r_bmag  <= w_bmag[WIDTH-1:0];
              r_quo   <= w_amag[WIDTH-1:0];
              r_rem   <= '0;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            hi      <= w_hi_res;
            lo      <= w_lo_res;
          end
        end
        S_ZERO: begin
          r_state <= S_DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: cycle-timed arithmetic model checked every cycle, plus directed literal cases.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic in plain 64-bit integers.
  function automatic void ref_calc(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] rh, output logic [W-1:0] rl);
    bit uns;
    longint sx, sy, q, r;
    logic [63:0] p;
`ifdef MULDIV_UNSIGNED_EN
    uns = o[1];
`else
    uns = 1'b0;
`endif
    sx = uns ? longint'(x) : longint'($signed(x));
    sy = uns ? longint'(y) : longint'($signed(y));
    if (!o[0]) begin
      p  = sx * sy;
      rh = p[63:32];
      rl = p[31:0];
    end else begin
      q  = sx / sy;
      r  = sx % sy;
      p  = q;
      rl = p[31:0];
      p  = r;
      rh = p[31:0];
    end
  endfunction

  // Cycle-timed model: acceptance only when not busy; result appears LAT edges later.
  bit           m_ok = 0, m_busy = 0, m_done = 0, m_dz = 0, m_keep = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  longint       m_cyc = 0, m_done_at = 0;

  always @(posedge clk) begin
    bit was_busy;
    if (reset) begin
      m_ok = 1; m_busy = 0; m_done = 0; m_dz = 0; m_hi = '0; m_lo = '0;
    end else begin
      was_busy = m_busy;
      m_done   = 0;
      if (m_busy && m_cyc == m_done_at) begin
        m_busy = 0;
        m_done = 1;
        if (!m_keep) begin m_hi = m_phi; m_lo = m_plo; end
      end
      if (!was_busy && start) begin
        m_busy = 1;
        m_dz   = op[0] && (b == '0);
        m_keep = m_dz;
        m_done_at = m_cyc + (m_dz ? 1 : W);
        if (!m_dz) ref_calc(op, a, b, m_phi, m_plo);
      end
    end
    m_cyc++;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("div_zero", div_zero, m_dz);
    end
  end

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
    start = 1'b1; op = o; a = x; b = y;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
    end while (!done && lat < 100);
    if (!done) chk("done_timeout", 64'(lat), 64'(W + 1));
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] sp [5];
    sp[0] = '0; sp[1] = 1; sp[2] = '1; sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    if ($urandom_range(0, 1) == 0) return W'($urandom_range(0, 300));
    return $urandom;
  endfunction

  initial begin
    int lat, dones;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset = 1'b0;
    @(negedge clk);

    do_op(2'b00, 32'hFFFF_FFFE, 32'd3, lat);
    chk("t1_lat", 64'(lat), 64'd33);
    chk("t1_hi", hi, 32'hFFFF_FFFF);
    chk("t1_lo", lo, 32'hFFFF_FFFA);
    @(negedge clk);
    chk("t1_busy_after", busy, 0);

    do_op(2'b01, 32'hFFFF_FFF9, 32'd2, lat);
    chk("t2_lo", lo, 32'hFFFF_FFFD);
    chk("t2_hi", hi, 32'hFFFF_FFFF);
    chk("t2_dz", div_zero, 0);

    do_op(2'b01, 32'h0000_0891, 32'h40, lat);
    chk("prep_hi", hi, 32'h11);
    chk("prep_lo", lo, 32'h22);
    do_op(2'b01, 32'd5, 32'd0, lat);
    chk("t3_lat", 64'(lat), 64'd2);
    chk("t3_dz", div_zero, 1);
    chk("t3_hi", hi, 32'h11);
    chk("t3_lo", lo, 32'h22);

    do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("t4_lo", lo, 32'h8000_0000);
    chk("t4_hi", hi, 32'h0);
    chk("t4_dz", div_zero, 0);

    do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
`ifdef MULDIV_UNSIGNED_EN
    chk("t6_hi", hi, 32'hFFFF_FFFE);
    chk("t6_lo", lo, 32'h0000_0001);
`else
    chk("t6_hi", hi, 32'h0);
    chk("t6_lo", lo, 32'h1);
`endif

    // Reset mid-run with an ignored extra start.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd9;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = (c == 5);
      a = 32'd100; b = 32'd100;
      if (c == 10) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_hi", hi, 0);
    chk("t5_lo", lo, 0);
    dones = 0;
    repeat (W + 8) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("t5_no_done", 64'(dones), 0);

    // Randomized traffic; starts while busy are expected to be ignored.
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 999) == 0);
      start = ($urandom_range(0, 7) == 0);
      op    = 2'($urandom_range(0, 3));
      a     = pick();
      b     = pick();
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
